// File: rtl/result_sel_pipe.sv
`default_nettype none
// ============================================================================
// Module   : result_sel_pipe
// Brief    : Registered N:1 result selector with valid/ready handshake and a
//            sticky out-of-range select flag. Define RESULT_SEL_PIPE_SKID_EN
//            to add a skid register behind the output register.
// Revision : 1.0
// ============================================================================
module result_sel_pipe #(
  parameter int  WIDTH  = 32,
  parameter int  NUM_IN = 8,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    sel_err,
  input  logic                    clear_err
);

  localparam logic [SEL_W:0] c_NUM_IN = (SEL_W+1)'(NUM_IN);

  logic             w_in_fire;
  logic             w_sel_ok;
  logic [WIDTH-1:0] w_word;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             sel_err_q, sel_err_d;

  assign w_in_fire = in_valid && in_ready;
  assign w_sel_ok  = {1'b0, sel} < c_NUM_IN;

  // Unmatched select values fall through to zero.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) w_word = in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    sel_err_d = sel_err_q;
    if (w_in_fire && !w_sel_ok) sel_err_d = 1'b1;
    else if (clear_err)         sel_err_d = 1'b0;
  end

`ifdef RESULT_SEL_PIPE_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
  logic             in_ready_q, in_ready_d;

  // in_ready is low whenever skid is full, so no input arrives while skid drains.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_sel_d   = skid_sel_q;
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_sel_d    = skid_sel_q;
        skid_valid_d = 1'b0;
      end else if (w_in_fire) begin
        out_valid_d = 1'b1;
        out_data_d  = w_word;
        out_sel_d   = sel;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (w_in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = w_word;
      skid_sel_d   = sel;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_sel_q   <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_sel_q   <= skid_sel_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
`else
  logic en_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (w_in_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = w_word;
      out_sel_d   = sel;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Keeps in_ready low from reset until the first edge after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) en_q <= 1'b0;
    else       en_q <= 1'b1;
  end

  assign in_ready = en_q && (!out_valid_q || out_ready);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign sel_err   = sel_err_q;

endmodule
`default_nettype wire

// File: tb/tb_result_sel_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_sel_pipe
// Brief    : Scoreboard bench for result_sel_pipe (NUM_IN = 6, WIDTH = 32).
// Revision : 1.0
// ============================================================================
module tb_result_sel_pipe;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 6;
  localparam int SEL_W  = 3;
`ifdef RESULT_SEL_PIPE_SKID_EN
  localparam int HOLD = 2;
`else
  localparam int HOLD = 1;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    in_valid, in_ready;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    out_valid, out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    sel_err, clear_err;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [SEL_W-1:0] s;
  } res_t;

  res_t             sb[$];
  int               checks = 0;
  int               failures = 0;
  int               accept_count = 0;
  bit               err_model = 1'b0;
  bit               held = 1'b0;
  logic [WIDTH-1:0] held_data;
  logic [SEL_W-1:0] held_sel;

  result_sel_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sel  (out_sel),
    .sel_err  (sel_err),
    .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the selected word, or zero when the index names no input.
  function automatic res_t model(input logic [NUM_IN*WIDTH-1:0] d, input logic [SEL_W-1:0] s);
    res_t r;
    r.s = s;
    r.d = '0;
    if (int'(s) < NUM_IN) r.d = d[int'(s)*WIDTH +: WIDTH];
    return r;
  endfunction

  // Input side: record accepted requests and track the sticky error flag.
  always @(negedge clk) begin
    if (reset) begin
      err_model = 1'b0;
    end else begin
      check("sel_err", sel_err, err_model);
      if (in_valid && in_ready) begin
        sb.push_back(model(in_data, sel));
        accept_count++;
      end
      if (in_valid && in_ready && int'(sel) >= NUM_IN) err_model = 1'b1;
      else if (clear_err)                              err_model = 1'b0;
    end
  end

  // Output side: compare each delivered result and check hold stability.
  always @(negedge clk) begin
    res_t e;
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, held_data);
        check("hold_sel", out_sel, held_sel);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got data 0x%0h sel %0d with empty scoreboard", out_data, out_sel);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.d);
          check("out_sel", out_sel, e.s);
        end
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
      held_sel  = out_sel;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 20) begin
      step();
      n++;
    end
    check(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int a0;
    reset = 1'b1; in_valid = 1'b0; sel = '0; out_ready = 1'b0; clear_err = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, 64'd0);
    check("reset_out_sel", out_sel, 64'd0);
    check("reset_sel_err", sel_err, 1'b0);
    reset = 1'b0;
    step();
    check("idle_in_ready", in_ready, 1'b1);
    check("idle_out_valid", out_valid, 1'b0);

    // Basic select
    for (int k = 0; k < NUM_IN; k++) in_data[k*WIDTH +: WIDTH] = 32'h1000_0000 + k;
    sel = 3'd5; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("basic_valid", out_valid, 1'b1);
    check("basic_data", out_data, 64'h1000_0005);
    check("basic_sel", out_sel, 64'd5);
    step();

    // Streaming without gaps
    for (int i = 0; i < NUM_IN; i++) begin
      sel = SEL_W'(i); in_valid = 1'b1;
      step();
      check("stream_valid", out_valid, 1'b1);
      check("stream_sel", out_sel, 64'(i));
    end
    in_valid = 1'b0;
    step();
    check("stream_done", out_valid, 1'b0);

    // Backpressure capacity
    a0 = accept_count;
    sel = 3'd1; in_valid = 1'b1;
    step();
    out_ready = 1'b0;
    repeat (4) begin
      sel = SEL_W'($urandom_range(0, NUM_IN-1));
      step();
    end
    check("bp_accepted", 64'(accept_count - a0), 64'(HOLD));
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (HOLD) step();
    check("bp_drained", out_valid, 1'b0);
    check("bp_in_ready_back", in_ready, 1'b1);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Out-of-range select and sticky error
    sel = 3'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("oor_data", out_data, 64'd0);
    check("oor_sel", out_sel, 64'd7);
    check("oor_err", sel_err, 1'b1);
    repeat (3) step();
    check("oor_err_sticky", sel_err, 1'b1);
    sel = 3'd6; in_valid = 1'b1; clear_err = 1'b1;
    step();
    in_valid = 1'b0;
    check("oor_set_beats_clear", sel_err, 1'b1);
    step();
    clear_err = 1'b0;
    check("oor_clear", sel_err, 1'b0);
    drain("oor_drain");

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NUM_IN; k++) in_data[k*WIDTH +: WIDTH] = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      sel       = SEL_W'($urandom_range(0, 7));
      clear_err = ($urandom_range(0, 9) == 0);
      step();
    end
    clear_err = 1'b0;
    drain("rand_drain");

    // Reset while results are held
    out_ready = 1'b0; in_valid = 1'b1; sel = 3'd2;
    repeat (3) step();
    check("pre_reset_valid", out_valid, 1'b1);
    #1;
    reset = 1'b1;
    sb.delete();
    #1;
    check("async_reset_valid", out_valid, 1'b0);
    check("async_reset_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      step();
      check("post_reset_no_stale", out_valid, 1'b0);
    end
    check("post_reset_in_ready", in_ready, 1'b1);
    sel = 3'd4; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("post_reset_sel", out_sel, 64'd4);
    drain("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/result_sel_pipe.md
# result_sel_pipe

Parametrised, registered N-input result selector for the Mini-MIPS datapath. It is the successor to the fixed 32-bit 8:1 combinational multiplexer and sits between the execute-stage result sources (ALU, shifter, LUI, PC+4, memory data, ...) and the write-back register. It adds configurable width and input count, a one-stage output register with valid/ready handshake, and optional skid buffering. It also detects select values that name no input.

## Interface
- WIDTH, 32: data width of each input channel and of the output.
- NUM_IN, 8: number of input channels, 2..16.
- SEL_W (localparam), $clog2(NUM_IN): select width.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream offers a selection this cycle.
- in_ready  out  1  block can accept; transfer when in_valid && in_ready.
- sel  in  SEL_W  channel index; sampled on transfer.
- in_data  in  NUM_IN*WIDTH  flat inputs; channel k = in_data[k*WIDTH +: WIDTH].
- out_valid  out  1  out_data/out_sel hold a valid result.
- out_ready  in  1  downstream accepts; transfer when out_valid && out_ready.
- out_data  out  WIDTH  selected channel value.
- out_sel  out  SEL_W  index that produced out_data (tag for debug/forwarding).
- sel_err  out  1  sticky flag, set when an accepted sel >= NUM_IN.
- clear_err  in  1  synchronous clear of sel_err.

## Operation
- On input transfer, the block captures the word in_data[sel*WIDTH +: WIDTH] together with sel.
- If sel >= NUM_IN (possible only when NUM_IN is not a power of 2):
  - the captured data is all zeros and the captured tag is sel;
  - sel_err sets on the next edge.
- The result is presented on out_data/out_sel with out_valid = 1 until the output transfer completes.
- While out_valid = 1 && out_ready = 0, out_data and out_sel are stable.
- sel_err behaviour:
  - set has priority over clear_err in the same cycle;
  - otherwise clear_err = 1 clears it;
  - otherwise it holds.
- No data is dropped or duplicated. Results leave in acceptance order.
- Reset values: out_valid = 0, out_data = 0, out_sel = 0, sel_err = 0, all internal valid bits 0.
  - in_ready = 1 in the cycle after reset deasserts.
  - in_ready is 0 while reset is high.
- Reset asserted mid-transfer discards all held results immediately (asynchronous).

## Timing
- Latency: accepted at edge N → out_valid = 1 after edge N, i.e. 1 cycle.
- Throughput: one transfer per cycle when out_ready = 1 continuously.
- Simultaneous input and output transfer on a full main register: the old result leaves and the new one loads on the same edge, with no bubble.
- in_ready behaviour depends on configuration (see below). in_data must not feed back combinationally to in_ready.
- The in_valid → out_valid path is always registered. There is no combinational path from in_data to out_data.

## Configuration
- Macro: RESULT_SEL_PIPE_SKID_EN.
- Defined:
  - a 2-entry buffer: main output register plus a skid register;
  - in_ready is a flop output, equal to !skid_valid;
  - when the main register is full and out_ready = 0 during an input transfer, the new result goes to the skid register;
  - when the main register drains, the skid entry moves to main on the same edge;
  - after out_ready drops, up to 1 further transfer is accepted.
- Not defined:
  - a single output register;
  - in_ready = !out_valid || out_ready, combinational from out_ready;
  - skid logic is absent.
- The output sequence, latency and sel_err behaviour are identical in both builds.

## Test plan
- Reset/idle: reset = 1 then 0 → out_valid = 0, out_data = 0, sel_err = 0, in_ready = 1.
- Basic select, NUM_IN = 8, WIDTH = 32:
  - stimulus: channel k = 0x1000_0000 + k, sel = 5, out_ready = 1;
  - response: one cycle later out_data = 0x1000_0005, out_sel = 5, out_valid = 1.
- Streaming: sel = 0..7 on consecutive cycles with out_ready = 1 → 8 results in order, one per cycle, no gaps.
- Backpressure with SKID_EN:
  - stimulus: out_ready = 0 after the first result, in_valid held;
  - response: exactly 2 results are held and in_ready = 0;
  - then out_ready = 1 → both results drain in order and in_ready returns to 1 after the skid entry empties.
  - Without SKID_EN: only 1 result is held.
- Out-of-range, NUM_IN = 6: sel = 7 → out_data = 0, out_sel = 7, sel_err = 1 and stays set.
  - clear_err together with a new sel = 6 → sel_err stays 1.
  - clear_err alone → sel_err = 0.
- Reset mid-stream: assert reset while out_valid = 1 and the skid entry is full → out_valid = 0 immediately, with no stale result after release.
